// File: rtl/sonar_down_timer.sv
// Down-counting timer with one-shot or periodic reload and a registered terminal-count pulse.
// The FSM is IDLE/RUN. Abort overrides everything except reset and loading the reload register.
module sonar_down_timer #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             abort,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] reload_q;
   logic             done_q;
   logic [WIDTH-1:0] eff_reload_d;

   // A load in the same cycle takes effect immediately for start and reload decisions.
   assign eff_reload_d = load ? load_value : reload_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         q_q      <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (load) begin
            reload_q <= load_value;
         end
         if (abort) begin
            state_q <= IDLE;
            q_q     <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     if (eff_reload_d != '0) begin
                        q_q     <= eff_reload_d;
                        state_q <= RUN;
                     end
                  end else if (load) begin
                     q_q <= load_value;
                  end
               end
               RUN: begin
                  // A restart discards the running count without a done pulse.
                  if (start) begin
                     q_q <= eff_reload_d;
                  end else if (enable) begin
                     if (q_q != '0) begin
                        q_q <= q_q - ONE;
                     end else begin
                        done_q <= 1'b1;
                        if (auto_reload) begin
                           q_q <= eff_reload_d;
                        end else begin
                           state_q <= IDLE;
                        end
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
                  q_q     <= '0;
               end
            endcase
         end
      end
   end

   assign q    = q_q;
   assign busy = (state_q == RUN);
   assign done = done_q;

endmodule

// File: tb/tb_sonar_down_timer.sv
// Directed self-checking bench for sonar_down_timer; checks {busy, done, q} after each edge.
module tb_sonar_down_timer;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       load;
   logic [5:0] load_value;
   logic       start;
   logic       abort;
   logic       auto_reload;
   logic [5:0] q;
   logic       busy;
   logic       done;

   int n_checks;
   int n_fail;

   sonar_down_timer #(.WIDTH(6)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .load        (load),
      .load_value  (load_value),
      .start       (start),
      .abort       (abort),
      .auto_reload (auto_reload),
      .q           (q),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      reset = 1'b0; enable = 1'b0; load = 1'b0; load_value = '0;
      start = 1'b0; abort = 1'b0; auto_reload = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1; load = 1'b1; load_value = 6'd9; start = 1'b1; enable = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({busy, done, q} !== {1'b0, 1'b0, 6'd0}) begin
         n_fail++;
         $display("FAIL reset_state: busy=%0b done=%0b q=%0d, expected busy=0 done=0 q=0", busy, done, q);
      end
      clear_inputs();
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if ({busy, done, q} !== {1'b0, 1'b0, 6'd0}) begin
         n_fail++;
         $display("FAIL reset_reload_zero: busy=%0b done=%0b q=%0d, expected busy=0 done=0 q=0", busy, done, q);
      end
      $display("test_reset complete");
   endtask

   task automatic test_one_shot();
      clear_inputs();
      load = 1'b1; load_value = 6'd5;
      tick();
      load = 1'b0;
      n_checks++;
      if ({busy, done, q} !== {1'b0, 1'b0, 6'd5}) begin
         n_fail++;
         $display("FAIL one_shot_load: busy=%0b done=%0b q=%0d, expected busy=0 done=0 q=5", busy, done, q);
      end
      start = 1'b1; enable = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if ({busy, done, q} !== {1'b1, 1'b0, 6'd5}) begin
         n_fail++;
         $display("FAIL one_shot_start: busy=%0b done=%0b q=%0d, expected busy=1 done=0 q=5", busy, done, q);
      end
      for (int k = 4; k >= 0; k--) begin
         tick();
         n_checks++;
         if ({busy, done, q} !== {1'b1, 1'b0, 6'(k)}) begin
            n_fail++;
            $display("FAIL one_shot_count: busy=%0b done=%0b q=%0d, expected busy=1 done=0 q=%0d", busy, done, q, k);
         end
      end
      tick();
      n_checks++;
      if ({busy, done, q} !== {1'b0, 1'b1, 6'd0}) begin
         n_fail++;
         $display("FAIL one_shot_done: busy=%0b done=%0b q=%0d, expected busy=0 done=1 q=0", busy, done, q);
      end
      tick();
      n_checks++;
      if ({busy, done, q} !== {1'b0, 1'b0, 6'd0}) begin
         n_fail++;
         $display("FAIL one_shot_after: busy=%0b done=%0b q=%0d, expected busy=0 done=0 q=0", busy, done, q);
      end
      $display("test_one_shot complete");
   endtask

   task automatic test_periodic();
      clear_inputs();
      auto_reload = 1'b1;
      load = 1'b1; load_value = 6'd3;
      tick();
      load = 1'b0; start = 1'b1; enable = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if ({busy, done, q} !== {1'b1, 1'b0, 6'd3}) begin
         n_fail++;
         $display("FAIL periodic_start: busy=%0b done=%0b q=%0d, expected busy=1 done=0 q=3", busy, done, q);
      end
      for (int p = 0; p < 3; p++) begin
         for (int k = 2; k >= 0; k--) begin
            tick();
            n_checks++;
            if ({busy, done, q} !== {1'b1, 1'b0, 6'(k)}) begin
               n_fail++;
               $display("FAIL periodic_count: period=%0d busy=%0b done=%0b q=%0d, expected busy=1 done=0 q=%0d", p, busy, done, q, k);
            end
         end
         tick();
         n_checks++;
         if ({busy, done, q} !== {1'b1, 1'b1, 6'd3}) begin
            n_fail++;
            $display("FAIL periodic_done: period=%0d busy=%0b done=%0b q=%0d, expected busy=1 done=1 q=3", p, busy, done, q);
         end
      end
      abort = 1'b1;
      tick();
      abort = 1'b0; auto_reload = 1'b0;
      n_checks++;
      if ({busy, done, q} !== {1'b0, 1'b0, 6'd0}) begin
         n_fail++;
         $display("FAIL periodic_abort: busy=%0b done=%0b q=%0d, expected busy=0 done=0 q=0", busy, done, q);
      end
      $display("test_periodic complete");
   endtask

   task automatic test_enable_gating();
      logic       en_tab   [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [5:0] q_tab    [9] = '{6'd3, 6'd3, 6'd2, 6'd2, 6'd1, 6'd1, 6'd0, 6'd0, 6'd0};
      logic       done_tab [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic       busy_tab [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      clear_inputs();
      load = 1'b1; load_value = 6'd4;
      tick();
      load = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         enable = en_tab[i];
         tick();
         n_checks++;
         if ({busy, done, q} !== {busy_tab[i], done_tab[i], q_tab[i]}) begin
            n_fail++;
            $display("FAIL enable_gating: step=%0d busy=%0b done=%0b q=%0d, expected busy=%0b done=%0b q=%0d",
                     i, busy, done, q, busy_tab[i], done_tab[i], q_tab[i]);
         end
      end
      enable = 1'b0;
      $display("test_enable_gating complete");
   endtask

   task automatic test_boundary();
      clear_inputs();
      load = 1'b1; load_value = 6'd0; start = 1'b1; enable = 1'b1;
      tick();
      load = 1'b0;
      tick();
      start = 1'b0;
      n_checks++;
      if ({busy, done, q} !== {1'b0, 1'b0, 6'd0}) begin
         n_fail++;
         $display("FAIL start_zero_reload: busy=%0b done=%0b q=%0d, expected busy=0 done=0 q=0", busy, done, q);
      end
      load = 1'b1; load_value = 6'd63;
      tick();
      load = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if ({busy, done, q} !== {1'b1, 1'b0, 6'd63}) begin
         n_fail++;
         $display("FAIL full_range_start: busy=%0b done=%0b q=%0d, expected busy=1 done=0 q=63", busy, done, q);
      end
      for (int k = 62; k >= 0; k--) begin
         tick();
         n_checks++;
         if ({busy, done, q} !== {1'b1, 1'b0, 6'(k)}) begin
            n_fail++;
            $display("FAIL full_range_count: busy=%0b done=%0b q=%0d, expected busy=1 done=0 q=%0d", busy, done, q, k);
         end
      end
      tick();
      n_checks++;
      if ({busy, done, q} !== {1'b0, 1'b1, 6'd0}) begin
         n_fail++;
         $display("FAIL full_range_done: busy=%0b done=%0b q=%0d, expected busy=0 done=1 q=0", busy, done, q);
      end
      tick();
      n_checks++;
      if ({busy, done, q} !== {1'b0, 1'b0, 6'd0}) begin
         n_fail++;
         $display("FAIL full_range_no_wrap: busy=%0b done=%0b q=%0d, expected busy=0 done=0 q=0", busy, done, q);
      end
      $display("test_boundary complete");
   endtask

   task automatic test_priority();
      clear_inputs();
      load = 1'b1; load_value = 6'd5;
      tick();
      load = 1'b0; start = 1'b1; enable = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      n_checks++;
      if ({busy, done, q} !== {1'b1, 1'b0, 6'd2}) begin
         n_fail++;
         $display("FAIL priority_setup: busy=%0b done=%0b q=%0d, expected busy=1 done=0 q=2", busy, done, q);
      end
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      n_checks++;
      if ({busy, done, q} !== {1'b0, 1'b0, 6'd0}) begin
         n_fail++;
         $display("FAIL abort_over_start: busy=%0b done=%0b q=%0d, expected busy=0 done=0 q=0", busy, done, q);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      load = 1'b1; load_value = 6'd7;
      tick();
      load = 1'b0;
      n_checks++;
      if ({busy, done, q} !== {1'b1, 1'b0, 6'd4}) begin
         n_fail++;
         $display("FAIL load_in_run: busy=%0b done=%0b q=%0d, expected busy=1 done=0 q=4", busy, done, q);
      end
      tick(); tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if ({busy, done, q} !== {1'b1, 1'b0, 6'd7}) begin
         n_fail++;
         $display("FAIL restart_in_run: busy=%0b done=%0b q=%0d, expected busy=1 done=0 q=7", busy, done, q);
      end
      tick();
      n_checks++;
      if ({busy, done, q} !== {1'b1, 1'b0, 6'd6}) begin
         n_fail++;
         $display("FAIL restart_no_done: busy=%0b done=%0b q=%0d, expected busy=1 done=0 q=6", busy, done, q);
      end
      abort = 1'b1; load = 1'b1; load_value = 6'd2;
      tick();
      abort = 1'b0; load = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if ({busy, done, q} !== {1'b1, 1'b0, 6'd2}) begin
         n_fail++;
         $display("FAIL abort_keeps_load: busy=%0b done=%0b q=%0d, expected busy=1 done=0 q=2", busy, done, q);
      end
      auto_reload = 1'b1;
      tick(); tick();
      load = 1'b1; load_value = 6'd9;
      tick();
      load = 1'b0;
      n_checks++;
      if ({busy, done, q} !== {1'b1, 1'b1, 6'd9}) begin
         n_fail++;
         $display("FAIL terminal_with_load: busy=%0b done=%0b q=%0d, expected busy=1 done=1 q=9", busy, done, q);
      end
      abort = 1'b1;
      tick();
      clear_inputs();
      $display("test_priority complete");
   endtask

   task automatic test_reset_midrun();
      clear_inputs();
      load = 1'b1; load_value = 6'd5;
      tick();
      load = 1'b0; start = 1'b1; enable = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      n_checks++;
      if ({busy, done, q} !== {1'b1, 1'b0, 6'd3}) begin
         n_fail++;
         $display("FAIL midrun_setup: busy=%0b done=%0b q=%0d, expected busy=1 done=0 q=3", busy, done, q);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if ({busy, done, q} !== {1'b0, 1'b0, 6'd0}) begin
         n_fail++;
         $display("FAIL midrun_reset: busy=%0b done=%0b q=%0d, expected busy=0 done=0 q=0", busy, done, q);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if ({busy, done, q} !== {1'b0, 1'b0, 6'd0}) begin
         n_fail++;
         $display("FAIL midrun_start_ignored: busy=%0b done=%0b q=%0d, expected busy=0 done=0 q=0", busy, done, q);
      end
      $display("test_reset_midrun complete");
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clear_inputs();
      test_reset();
      test_one_shot();
      test_periodic();
      test_enable_gating();
      test_boundary();
      test_priority();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
